// File: rtl/dram_burst_reader.sv
// Burst read engine for a simple dual-port RAM.
// A start request (base address + length) makes the engine issue consecutive read
// addresses. It tracks reads still in flight through the fixed RAM read latency and
// buffers the returned words in a small FIFO. Words leave on a valid/ready stream
// with a last flag. Credit-based issue control means the FIFO can never overflow.
module dram_burst_reader #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   start_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned FIFO_DEPTH = RD_LAT + 2;
  localparam int unsigned LEN_W      = ADDR_W + 1;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;

  // in-flight pipe: bit i set means a read issued i+1 clocks ago
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_last;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  in_flight;

  logic accept;
  logic issue_ok;
  logic issue;
  logic is_last_issue;
  logic push;
  logic pop;
  logic drained;
  logic done_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_addr = addr;
  assign busy    = (state != S_IDLE);

  assign accept        = (state == S_IDLE) && start && (start_len != '0);
  assign is_last_issue = (remaining == LEN_W'(1));
  assign issue_ok      = ({1'b0, fifo_count} + {1'b0, in_flight}) < DEPTH_LIM;
  assign issue         = (state == S_READ) && issue_ok;
  assign push          = pipe_vld[RD_LAT-1];

  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? fifo_data[rptr] : '0;
  assign m_last  = m_valid && fifo_last[rptr];

  // The final pop is counted here so done appears the clock right after the last handshake.
  assign drained = (in_flight == '0) &&
                   ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

  // Count of reads issued but not yet pushed into the FIFO
  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      in_flight = in_flight + CNT_W'(pipe_vld[i]);
    end
  end

  // Next-state and done-pulse decode
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (start_len != '0) begin
            state_nxt = S_READ;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      S_READ: begin
        if (issue && is_last_issue) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and registered done pulse
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Read address and remaining-word counter
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (accept) begin
      addr      <= start_addr;
      remaining <= start_len;
    end else if (issue) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

  // Shift register following each issued read through the RAM latency
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue && is_last_issue;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  // FIFO storage; contents are never observed while the FIFO is empty
  always_ff @(posedge rd_clk) begin
    if (push) begin
      fifo_data[wptr] <= rd_data;
      fifo_last[wptr] <= pipe_last[RD_LAT-1];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wptr <= ptr_inc(wptr);
      end
      if (pop) begin
        rptr <= ptr_inc(rptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_burst_reader.sv
// Testbench for dram_burst_reader. Two instances (RD_LAT=1 and RD_LAT=2) share the
// stimulus, and each instance has its own RAM model with mem[a]=a. The expected beats
// come from plain address arithmetic.
`timescale 1ns/1ps
module tb_dram_burst_reader;

  logic        clk = 1'b0;
  logic        rst, start, m_ready;
  logic [10:0] start_addr;
  logic [11:0] start_len;

  logic [10:0] rd_addr1, rd_addr2;
  logic [15:0] rd_data1, rd_data2, ram2_q;
  logic [15:0] m_data1, m_data2;
  logic        m_valid1, m_valid2, m_last1, m_last2;
  logic        busy1, busy2, done1, done2;

  always #5 clk = ~clk;

  dram_burst_reader #(.ADDR_W(11), .DATA_W(16), .RD_LAT(1)) u_dut1 (
    .rd_clk(clk), .rd_rst(rst), .start(start), .start_addr(start_addr),
    .start_len(start_len), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready), .m_last(m_last1),
    .busy(busy1), .done(done1)
  );

  dram_burst_reader #(.ADDR_W(11), .DATA_W(16), .RD_LAT(2)) u_dut2 (
    .rd_clk(clk), .rd_rst(rst), .start(start), .start_addr(start_addr),
    .start_len(start_len), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready), .m_last(m_last2),
    .busy(busy2), .done(done2)
  );

  // RAM models: mem[a] = a, latency 1 and 2
  always @(posedge clk) begin
    rd_data1 <= {5'b0, rd_addr1};
    ram2_q   <= {5'b0, rd_addr2};
    rd_data2 <= ram2_q;
  end

  typedef struct {
    int          cyc;
    logic        last;
    logic [15:0] data;
  } beat_t;

  beat_t q1[$];
  beat_t q2[$];
  int    done_q1[$];
  int    done_q2[$];
  int    start_q[$];
  int    cyc = 0;
  int    stall_err1 = 0, stall_err2 = 0, credit_err1 = 0, credit_err2 = 0;
  int    n_cmp = 0, n_fail = 0;

  // Monitor: log beats, done pulses and start samples. Also count stall-stability
  // and outstanding-read violations.
  logic        prev_stall1 = 0, prev_stall2 = 0, prev_last1 = 0, prev_last2 = 0;
  logic        prev_busy1 = 0, prev_busy2 = 0, prev_rst = 0;
  logic [15:0] prev_data1 = 0, prev_data2 = 0;
  logic [10:0] prev_addr1 = 0, prev_addr2 = 0;
  int          iss1 = 0, iss2 = 0, pop1 = 0, pop2 = 0;
  always @(negedge clk) begin
    beat_t bt;
    cyc++;
    if (start === 1'b1) start_q.push_back(cyc);
    // instance 1
    if (prev_stall1 && !prev_rst &&
        !(m_valid1 === 1'b1 && m_data1 === prev_data1 && m_last1 === prev_last1))
      stall_err1++;
    if (busy1 === 1'b1 && prev_busy1 && rd_addr1 !== prev_addr1) iss1++;
    if (busy1 !== 1'b1) begin
      iss1 = 0; pop1 = 0;
    end else if (iss1 - pop1 > 3) credit_err1++;
    if (m_valid1 === 1'b1 && m_ready === 1'b1) begin
      bt.cyc = cyc; bt.last = m_last1; bt.data = m_data1;
      q1.push_back(bt);
      pop1++;
    end
    if (done1 === 1'b1) done_q1.push_back(cyc);
    prev_stall1 = (m_valid1 === 1'b1) && (m_ready === 1'b0);
    prev_data1 = m_data1; prev_last1 = m_last1;
    prev_addr1 = rd_addr1; prev_busy1 = (busy1 === 1'b1);
    // instance 2
    if (prev_stall2 && !prev_rst &&
        !(m_valid2 === 1'b1 && m_data2 === prev_data2 && m_last2 === prev_last2))
      stall_err2++;
    if (busy2 === 1'b1 && prev_busy2 && rd_addr2 !== prev_addr2) iss2++;
    if (busy2 !== 1'b1) begin
      iss2 = 0; pop2 = 0;
    end else if (iss2 - pop2 > 4) credit_err2++;
    if (m_valid2 === 1'b1 && m_ready === 1'b1) begin
      bt.cyc = cyc; bt.last = m_last2; bt.data = m_data2;
      q2.push_back(bt);
      pop2++;
    end
    if (done2 === 1'b1) done_q2.push_back(cyc);
    prev_stall2 = (m_valid2 === 1'b1) && (m_ready === 1'b0);
    prev_data2 = m_data2; prev_last2 = m_last2;
    prev_addr2 = rd_addr2; prev_busy2 = (busy2 === 1'b1);
    prev_rst = (rst === 1'b1);
  end

  // One-clock start pulse, then scramble the request inputs
  task automatic kick(input logic [10:0] a, input logic [11:0] l);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; start_len = l;
    @(posedge clk); #1;
    start = 1'b0; start_addr = 11'($urandom); start_len = 12'($urandom);
  endtask

  // Wait until both instances have produced a new done, with a cycle budget
  task automatic wait_done(input int d1, input int d2, input int max_cyc,
                           input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      if (done_q1.size() > d1 && done_q2.size() > d2) begin
        ok = 1'b1;
        break;
      end
    end
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; start_addr = '0; start_len = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rd_addr1 !== 11'h0) begin n_fail++; $display("FAIL reset_rd_addr1 got %h want 000", rd_addr1); end
    n_cmp++; if (m_data1 !== 16'h0) begin n_fail++; $display("FAIL reset_m_data1 got %h want 0000", m_data1); end
    n_cmp++; if (m_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid1 got %b want 0", m_valid1); end
    n_cmp++; if (m_last1 !== 1'b0) begin n_fail++; $display("FAIL reset_m_last1 got %b want 0", m_last1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    n_cmp++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done1 got %b want 0", done1); end
    n_cmp++; if ({rd_addr2, m_data2, m_valid2, m_last2, busy2, done2} !== '0) begin
      n_fail++; $display("FAIL reset_inst2 got %h want 0", {rd_addr2, m_data2, m_valid2, m_last2, busy2, done2});
    end
    rst = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // 0x010, len 4: latency, consecutive beats, last flag, done timing
  task automatic test_basic();
    int b1, b2, d1, d2, c0, cnt, dcnt;
    bit ok;
    beat_t b;
    m_ready = 1'b1;
    b1 = q1.size(); b2 = q2.size(); d1 = done_q1.size(); d2 = done_q2.size();
    kick(11'h010, 12'd4);
    wait_done(d1, d2, 60, 1'b0, ok);
    repeat (3) @(posedge clk);
    #1;
    c0 = start_q[$];
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got no done want done"); end
    for (int k = 0; k < 2; k++) begin
      cnt  = (k == 0) ? q1.size() - b1 : q2.size() - b2;
      dcnt = (k == 0) ? done_q1.size() - d1 : done_q2.size() - d2;
      n_cmp++; if (cnt != 4) begin n_fail++; $display("FAIL basic_count lat%0d got %0d want 4", k + 1, cnt); end
      n_cmp++; if (dcnt != 1) begin n_fail++; $display("FAIL basic_done_count lat%0d got %0d want 1", k + 1, dcnt); end
      for (int i = 0; i < 4 && i < cnt; i++) begin
        if (k == 0) b = q1[b1 + i]; else b = q2[b2 + i];
        n_cmp++; if (b.data !== 16'h0010 + 16'(i)) begin n_fail++; $display("FAIL basic_data lat%0d beat%0d got %h want %h", k + 1, i, b.data, 16'h0010 + 16'(i)); end
        n_cmp++; if (b.last !== (i == 3)) begin n_fail++; $display("FAIL basic_last lat%0d beat%0d got %b want %b", k + 1, i, b.last, (i == 3)); end
        n_cmp++; if (b.cyc != c0 + 3 + k + i) begin n_fail++; $display("FAIL basic_cycle lat%0d beat%0d got %0d want %0d", k + 1, i, b.cyc - c0, 3 + k + i); end
      end
      if (dcnt >= 1) begin
        n_cmp++;
        if (((k == 0) ? done_q1[d1] : done_q2[d2]) != c0 + 7 + k) begin
          n_fail++; $display("FAIL basic_done_cycle lat%0d got %0d want %0d", k + 1, ((k == 0) ? done_q1[d1] : done_q2[d2]) - c0, 7 + k);
        end
      end
    end
  endtask

  // 0x7FE, len 4: issued address sequence and data wrap modulo 2048
  task automatic test_wrap();
    int b1, b2, d1, d2, cnt;
    bit ok;
    beat_t b;
    logic [10:0] ea;
    m_ready = 1'b1;
    b1 = q1.size(); b2 = q2.size(); d1 = done_q1.size(); d2 = done_q2.size();
    kick(11'h7FE, 12'd4);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      ea = 11'((32'h7FE + j) % 2048);
      n_cmp++; if (rd_addr1 !== ea) begin n_fail++; $display("FAIL wrap_rd_addr1 step%0d got %h want %h", j, rd_addr1, ea); end
      n_cmp++; if (rd_addr2 !== ea) begin n_fail++; $display("FAIL wrap_rd_addr2 step%0d got %h want %h", j, rd_addr2, ea); end
    end
    wait_done(d1, d2, 60, 1'b0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout got no done want done"); end
    for (int k = 0; k < 2; k++) begin
      cnt = (k == 0) ? q1.size() - b1 : q2.size() - b2;
      n_cmp++; if (cnt != 4) begin n_fail++; $display("FAIL wrap_count lat%0d got %0d want 4", k + 1, cnt); end
      for (int i = 0; i < 4 && i < cnt; i++) begin
        if (k == 0) b = q1[b1 + i]; else b = q2[b2 + i];
        n_cmp++; if (b.data !== 16'((32'h7FE + i) % 2048)) begin n_fail++; $display("FAIL wrap_data lat%0d beat%0d got %h want %h", k + 1, i, b.data, 16'((32'h7FE + i) % 2048)); end
      end
    end
  endtask

  // Random address/length with random m_ready on both latencies
  task automatic test_backpressure();
    int b1, b2, d1, d2, cnt, dcnt, a, l;
    bit ok;
    beat_t b;
    for (int it = 0; it < 6; it++) begin
      a = int'($urandom_range(0, 2047));
      l = (it < 2) ? 16 : int'($urandom_range(1, 40));
      b1 = q1.size(); b2 = q2.size(); d1 = done_q1.size(); d2 = done_q2.size();
      m_ready = 1'($urandom_range(0, 1));
      kick(11'(a), 12'(l));
      wait_done(d1, d2, 1500, 1'b1, ok);
      repeat (4) @(posedge clk);
      #1;
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_timeout it%0d got no done want done", it); end
      for (int k = 0; k < 2; k++) begin
        cnt  = (k == 0) ? q1.size() - b1 : q2.size() - b2;
        dcnt = (k == 0) ? done_q1.size() - d1 : done_q2.size() - d2;
        n_cmp++; if (cnt != l) begin n_fail++; $display("FAIL bp_count lat%0d it%0d got %0d want %0d", k + 1, it, cnt, l); end
        n_cmp++; if (dcnt != 1) begin n_fail++; $display("FAIL bp_done_count lat%0d it%0d got %0d want 1", k + 1, it, dcnt); end
        for (int i = 0; i < l && i < cnt; i++) begin
          if (k == 0) b = q1[b1 + i]; else b = q2[b2 + i];
          n_cmp++; if (b.data !== 16'((a + i) % 2048) || b.last !== (i == l - 1)) begin
            n_fail++; $display("FAIL bp_beat lat%0d it%0d beat%0d got %h/%b want %h/%b", k + 1, it, i, b.data, b.last, 16'((a + i) % 2048), (i == l - 1));
          end
        end
      end
    end
    n_cmp++; if (stall_err1 != 0) begin n_fail++; $display("FAIL bp_stall_stable lat1 got %0d want 0", stall_err1); end
    n_cmp++; if (stall_err2 != 0) begin n_fail++; $display("FAIL bp_stall_stable lat2 got %0d want 0", stall_err2); end
    n_cmp++; if (credit_err1 != 0) begin n_fail++; $display("FAIL bp_outstanding lat1 got %0d want 0", credit_err1); end
    n_cmp++; if (credit_err2 != 0) begin n_fail++; $display("FAIL bp_outstanding lat2 got %0d want 0", credit_err2); end
  endtask

  // Zero-length request: done next clock, never busy, no beats
  task automatic test_len0();
    m_ready = 1'b1;
    kick(11'h123, 12'd0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_cmp++; if (done1 !== (j == 0) || done2 !== (j == 0)) begin n_fail++; $display("FAIL len0_done step%0d got %b%b want %b", j, done1, done2, (j == 0)); end
      n_cmp++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL len0_busy step%0d got %b%b want 00", j, busy1, busy2); end
      n_cmp++; if (m_valid1 !== 1'b0 || m_valid2 !== 1'b0) begin n_fail++; $display("FAIL len0_valid step%0d got %b%b want 00", j, m_valid1, m_valid2); end
    end
  endtask

  // A second start during an active burst is ignored
  task automatic test_busy_start();
    int b1, b2, d1, d2, cnt, dcnt;
    bit ok;
    beat_t b;
    m_ready = 1'b1;
    b1 = q1.size(); b2 = q2.size(); d1 = done_q1.size(); d2 = done_q2.size();
    kick(11'h300, 12'd8);
    @(posedge clk); #1;
    start = 1'b1; start_addr = 11'h555; start_len = 12'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d1, d2, 80, 1'b0, ok);
    repeat (12) @(posedge clk);
    #1;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL busy_start_timeout got no done want done"); end
    for (int k = 0; k < 2; k++) begin
      cnt  = (k == 0) ? q1.size() - b1 : q2.size() - b2;
      dcnt = (k == 0) ? done_q1.size() - d1 : done_q2.size() - d2;
      n_cmp++; if (cnt != 8) begin n_fail++; $display("FAIL busy_start_count lat%0d got %0d want 8", k + 1, cnt); end
      n_cmp++; if (dcnt != 1) begin n_fail++; $display("FAIL busy_start_done lat%0d got %0d want 1", k + 1, dcnt); end
      for (int i = 0; i < 8 && i < cnt; i++) begin
        if (k == 0) b = q1[b1 + i]; else b = q2[b2 + i];
        n_cmp++; if (b.data !== 16'h0300 + 16'(i) || b.last !== (i == 7)) begin
          n_fail++; $display("FAIL busy_start_beat lat%0d beat%0d got %h/%b want %h/%b", k + 1, i, b.data, b.last, 16'h0300 + 16'(i), (i == 7));
        end
      end
    end
  endtask

  // Reset in mid-burst aborts without done; the next burst works normally
  task automatic test_reset_mid();
    int b1, b2, d1, d2, cnt;
    bit ok, hit;
    beat_t b;
    m_ready = 1'b1;
    b1 = q1.size(); d1 = done_q1.size(); d2 = done_q2.size();
    kick(11'h200, 12'd8);
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (q1.size() >= b1 + 3) begin hit = 1'b1; break; end
    end
    n_cmp++; if (!hit) begin n_fail++; $display("FAIL rst_mid_wait got no 3 beats want 3 beats"); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({rd_addr1, m_data1, m_valid1, m_last1, busy1, done1} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs1 got %h want 0", {rd_addr1, m_data1, m_valid1, m_last1, busy1, done1});
    end
    n_cmp++; if ({rd_addr2, m_data2, m_valid2, m_last2, busy2, done2} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs2 got %h want 0", {rd_addr2, m_data2, m_valid2, m_last2, busy2, done2});
    end
    repeat (15) @(posedge clk);
    #1;
    n_cmp++; if (done_q1.size() != d1 || done_q2.size() != d2) begin
      n_fail++; $display("FAIL rst_mid_no_done got %0d/%0d want 0/0", done_q1.size() - d1, done_q2.size() - d2);
    end
    b1 = q1.size(); b2 = q2.size(); d1 = done_q1.size(); d2 = done_q2.size();
    kick(11'h100, 12'd2);
    wait_done(d1, d2, 40, 1'b0, ok);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst_mid_restart_timeout got no done want done"); end
    for (int k = 0; k < 2; k++) begin
      cnt = (k == 0) ? q1.size() - b1 : q2.size() - b2;
      n_cmp++; if (cnt != 2) begin n_fail++; $display("FAIL rst_mid_count lat%0d got %0d want 2", k + 1, cnt); end
      for (int i = 0; i < 2 && i < cnt; i++) begin
        if (k == 0) b = q1[b1 + i]; else b = q2[b2 + i];
        n_cmp++; if (b.data !== 16'h0100 + 16'(i) || b.last !== (i == 1)) begin
          n_fail++; $display("FAIL rst_mid_beat lat%0d beat%0d got %h/%b want %h/%b", k + 1, i, b.data, b.last, 16'h0100 + 16'(i), (i == 1));
        end
      end
    end
  endtask

  // Full-size burst: every address once, address returns to start
  task automatic test_full_len();
    int b1, b2, d1, d2, cnt, a;
    bit ok;
    beat_t b;
    m_ready = 1'b1;
    a = int'($urandom_range(0, 2047));
    b1 = q1.size(); b2 = q2.size(); d1 = done_q1.size(); d2 = done_q2.size();
    kick(11'(a), 12'd2048);
    wait_done(d1, d2, 2300, 1'b0, ok);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL full_timeout got no done want done"); end
    n_cmp++; if (rd_addr1 !== 11'(a) || rd_addr2 !== 11'(a)) begin
      n_fail++; $display("FAIL full_end_addr got %h/%h want %h", rd_addr1, rd_addr2, 11'(a));
    end
    for (int k = 0; k < 2; k++) begin
      cnt = (k == 0) ? q1.size() - b1 : q2.size() - b2;
      n_cmp++; if (cnt != 2048) begin n_fail++; $display("FAIL full_count lat%0d got %0d want 2048", k + 1, cnt); end
      for (int i = 0; i < 2048 && i < cnt; i++) begin
        if (k == 0) b = q1[b1 + i]; else b = q2[b2 + i];
        n_cmp++; if (b.data !== 16'((a + i) % 2048) || b.last !== (i == 2047)) begin
          n_fail++; $display("FAIL full_beat lat%0d beat%0d got %h/%b want %h/%b", k + 1, i, b.data, b.last, 16'((a + i) % 2048), (i == 2047));
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_busy_start();
    test_reset_mid();
    test_full_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
